// File: rtl/uv_mem_slv_pkg.sv
// Shared definitions for the memory-side bus responder: exception codes and sizing helpers.
// The exception codes are the ones the core fabric and the BIU expect.
package uv_mem_slv_pkg;

  typedef enum logic [1:0] {
    UV_EXCP_OK        = 2'b00,
    UV_EXCP_ACC_FAULT = 2'b01
  } uv_excp_e;

  // Width of an index into n entries; never narrower than one bit.
  function automatic int unsigned uv_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uv_sram_sp.sv
// Behavioural single-port synchronous SRAM with per-byte write enables.
// One-cycle read latency; read data during a write cycle is don't-care.
module uv_sram_sp #(
  parameter int MEM_AW = 12,
  parameter int DLEN   = 32,
  parameter int MLEN   = DLEN / 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [MEM_AW-1:0] addr,
  input  logic [MLEN-1:0]   be,
  input  logic [DLEN-1:0]   wdata,
  output logic [DLEN-1:0]   rdata
);

  logic [DLEN-1:0] mem [2**MEM_AW];

  // NOTE: the storage array and read register are deliberately not reset; a
  // reset on a RAM array would block SRAM-macro inference and is never needed.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < MLEN; b++) begin
          if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/uv_mem_slv.sv
// Req/rsp bus responder on a single-port SRAM: byte-masked writes, in-order
// responses for every request, access faults for addresses outside the window.
module uv_mem_slv
  import uv_mem_slv_pkg::*;
#(
  parameter int              ALEN      = 32,
  parameter int              DLEN      = 32,
  parameter int              MLEN      = DLEN / 8,
  parameter int              MEM_AW    = 12,
  parameter logic [ALEN-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int              RSP_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_vld,
  output logic            req_rdy,
  input  logic            req_read,
  input  logic [ALEN-1:0] req_addr,
  input  logic [MLEN-1:0] req_mask,
  input  logic [DLEN-1:0] req_data,
  output logic            rsp_vld,
  input  logic            rsp_rdy,
  output logic [1:0]      rsp_excp,
  output logic [DLEN-1:0] rsp_data
);

  localparam int OFF_LSB = $clog2(MLEN);
  localparam int IDX_MSB = MEM_AW + OFF_LSB;
  localparam int PW      = uv_idx_w(RSP_DEPTH);
  localparam int CW      = $clog2(RSP_DEPTH + 1);
  localparam int EW      = 2 + DLEN;

  // Address decode: anything at or beyond the window (including wrapped
  // addresses below the base) has a nonzero bit above the word index.
  logic [ALEN-1:0]   off;
  logic              fault;
  logic [MEM_AW-1:0] word_idx;

  assign off      = req_addr - BASE_ADDR;
  assign fault    = |off[ALEN-1:IDX_MSB];
  assign word_idx = off[IDX_MSB-1:OFF_LSB];

  logic accept;
  logic sram_en;
  logic [DLEN-1:0] sram_rdata;

  assign accept  = req_vld & req_rdy;
  assign sram_en = accept & ~fault;

  uv_sram_sp #(
    .MEM_AW (MEM_AW),
    .DLEN   (DLEN),
    .MLEN   (MLEN)
  ) u_sram (
    .clk   (clk),
    .en    (sram_en),
    .we    (~req_read),
    .addr  (word_idx),
    .be    (req_mask),
    .wdata (req_data),
    .rdata (sram_rdata)
  );

  // The access accepted last cycle; its response is formed from the SRAM output now.
  logic infl_vld;
  logic infl_read;
  logic infl_fault;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      infl_vld   <= 1'b0;
      infl_read  <= 1'b0;
      infl_fault <= 1'b0;
    end else begin
      infl_vld   <= accept;
      infl_read  <= req_read;
      infl_fault <= fault;
    end
  end

  uv_excp_e        infl_excp;
  logic [DLEN-1:0] infl_data;

  assign infl_excp = infl_fault ? UV_EXCP_ACC_FAULT : UV_EXCP_OK;
  assign infl_data = (infl_read && !infl_fault) ? sram_rdata : '0;

  // Response queue
  logic [EW-1:0] q_mem [RSP_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          q_empty;
  logic          pop;
  logic          q_pop;
  logic          push;

  assign q_empty = (count == '0);
  assign rsp_vld = ~q_empty | infl_vld;
  assign pop     = rsp_vld & rsp_rdy;
  assign q_pop   = pop & ~q_empty;
  // An in-flight response shown through the bypass and taken at once is never stored.
  assign push    = infl_vld & ~(pop & q_empty);

  // NOTE: every output of this block gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    rsp_excp = '0;
    rsp_data = '0;
    if (!q_empty) begin
      {rsp_excp, rsp_data} = q_mem[rd_ptr];
    end else if (infl_vld) begin
      rsp_excp = infl_excp;
      rsp_data = infl_data;
    end
  end

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (push) q_mem[wr_ptr] <= {infl_excp, infl_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)  wr_ptr <= next_ptr(wr_ptr);
      if (q_pop) rd_ptr <= next_ptr(rd_ptr);
      count <= count + CW'(push) - CW'(q_pop);
    end
  end

  // Occupancy includes the in-flight access so a queue slot is reserved at accept time.
  logic [CW:0] occ;

  assign occ     = {1'b0, count} + (CW+1)'(infl_vld);
  assign req_rdy = (occ - (CW+1)'(pop)) < (CW+1)'(RSP_DEPTH);

endmodule

// File: tb/tb_uv_mem_slv.sv
// Self-checking bench for uv_mem_slv: directed scenarios plus randomized traffic
// checked against a word-array memory model and an expected-response queue.
module tb_uv_mem_slv;

  localparam int          DEPTH = 3;
  localparam logic [31:0] BASE  = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_vld = 1'b0;
  logic        req_rdy;
  logic        req_read = 1'b1;
  logic [31:0] req_addr = '0;
  logic [3:0]  req_mask = '0;
  logic [31:0] req_data = '0;
  logic        rsp_vld;
  logic        rsp_rdy = 1'b0;
  logic [1:0]  rsp_excp;
  logic [31:0] rsp_data;

  uv_mem_slv #(
    .ALEN      (32),
    .DLEN      (32),
    .MEM_AW    (12),
    .BASE_ADDR (BASE),
    .RSP_DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_vld  (req_vld),
    .req_rdy  (req_rdy),
    .req_read (req_read),
    .req_addr (req_addr),
    .req_mask (req_mask),
    .req_data (req_data),
    .rsp_vld  (rsp_vld),
    .rsp_rdy  (rsp_rdy),
    .rsp_excp (rsp_excp),
    .rsp_data (rsp_data)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [33:0] exp_q[$];
  logic [33:0] got_q[$];
  logic [31:0] mdl_mem [4096];

  // Per-cycle samples taken 1 ns after the falling edge
  logic        s_acc, s_pop, s_vld, s_rdy, s_sram_en;
  logic [33:0] s_rsp;

  // Memory model: window of 4096 words above BASE, everything else faults.
  function automatic logic [33:0] model_req(input logic rd, input logic [31:0] addr,
                                            input logic [3:0] mask, input logic [31:0] data);
    logic [31:0] off;
    logic [11:0] idx;
    off = addr - BASE;
    if (off >= 32'h0000_4000) return {2'b01, 32'h0};
    idx = off[13:2];
    if (rd) return {2'b00, mdl_mem[idx]};
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) mdl_mem[idx][b*8 +: 8] = data[b*8 +: 8];
    end
    return {2'b00, 32'h0};
  endfunction

  task automatic step(input logic vld, input logic rd, input logic [31:0] addr,
                      input logic [3:0] mask, input logic [31:0] data, input logic rrdy);
    @(negedge clk);
    req_vld  = vld;
    req_read = rd;
    req_addr = addr;
    req_mask = mask;
    req_data = data;
    rsp_rdy  = rrdy;
    #1;
    s_acc     = req_vld & req_rdy;
    s_pop     = rsp_vld & rsp_rdy;
    s_vld     = rsp_vld;
    s_rdy     = req_rdy;
    s_rsp     = {rsp_excp, rsp_data};
    s_sram_en = dut.sram_en;
    if (s_acc) exp_q.push_back(model_req(rd, addr, mask, data));
    if (s_pop) got_q.push_back({rsp_excp, rsp_data});
  endtask

  task automatic idle(input logic rrdy);
    step(1'b0, 1'b1, 32'h0, 4'h0, 32'h0, rrdy);
  endtask

  task automatic drain(output bit ok);
    for (int i = 0; i < 40 && got_q.size() < exp_q.size(); i++) idle(1'b1);
    ok = (got_q.size() == exp_q.size());
  endtask

  task automatic clear_q();
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (rsp_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b want 0", rsp_vld); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (req_rdy !== 1'b1) begin errors++; $display("FAIL reset_req_rdy: got %b want 1", req_rdy); end
    checks++;
    if (rsp_excp !== 2'b00) begin errors++; $display("FAIL reset_excp: got %b want 00", rsp_excp); end
    checks++;
    if (rsp_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", rsp_data); end
  endtask

  task automatic test_write_read();
    clear_q();
    step(1'b1, 1'b0, 32'h8000_0010, 4'hF, 32'hDEAD_BEEF, 1'b1);
    checks++;
    if (s_acc !== 1'b1) begin errors++; $display("FAIL wr_accept: got %b want 1", s_acc); end
    step(1'b1, 1'b1, 32'h8000_0010, 4'h0, 32'h0, 1'b1);
    checks++;
    if (s_pop !== 1'b1 || s_rsp !== {2'b00, 32'h0}) begin
      errors++; $display("FAIL wr_rsp_t1: pop=%b rsp=%h want pop=1 rsp=%h", s_pop, s_rsp, {2'b00, 32'h0});
    end
    idle(1'b1);
    checks++;
    if (s_pop !== 1'b1 || s_rsp !== {2'b00, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL rd_rsp_t1: pop=%b rsp=%h want pop=1 rsp=%h", s_pop, s_rsp, {2'b00, 32'hDEAD_BEEF});
    end
  endtask

  task automatic test_mask();
    bit ok;
    clear_q();
    step(1'b1, 1'b0, 32'h8000_0010, 4'b0101, 32'h1122_3344, 1'b1);
    step(1'b1, 1'b1, 32'h8000_0010, 4'h0, 32'h0, 1'b1);
    drain(ok);
    checks++;
    if (!ok || got_q.size() != 2) begin
      errors++; $display("FAIL mask_count: got %0d want 2", got_q.size());
    end else begin
      checks++;
      if (got_q[1] !== {2'b00, 32'hDE22_BE44}) begin
        errors++; $display("FAIL mask_data: got %h want %h", got_q[1], {2'b00, 32'hDE22_BE44});
      end
    end
  endtask

  task automatic test_fault();
    bit ok;
    logic [33:0] want [5];
    want[0] = {2'b01, 32'h0};
    want[1] = {2'b01, 32'h0};
    want[2] = {2'b00, 32'hDE22_BE44};
    want[3] = {2'b00, 32'h0};
    want[4] = {2'b00, 32'hCAFE_F00D};
    clear_q();
    step(1'b1, 1'b1, 32'h7FFF_FFFC, 4'h0, 32'h0, 1'b1);
    checks++;
    if (s_acc !== 1'b1 || s_sram_en !== 1'b0) begin
      errors++; $display("FAIL fault_low_en: acc=%b sram_en=%b want 1/0", s_acc, s_sram_en);
    end
    step(1'b1, 1'b1, BASE + 32'h4000, 4'h0, 32'h0, 1'b1);
    checks++;
    if (s_acc !== 1'b1 || s_sram_en !== 1'b0) begin
      errors++; $display("FAIL fault_high_en: acc=%b sram_en=%b want 1/0", s_acc, s_sram_en);
    end
    step(1'b1, 1'b1, 32'h8000_0010, 4'h0, 32'h0, 1'b1);
    checks++;
    if (s_sram_en !== 1'b1) begin errors++; $display("FAIL valid_en: got %b want 1", s_sram_en); end
    step(1'b1, 1'b0, BASE + 32'h3FFC, 4'hF, 32'hCAFE_F00D, 1'b1);
    step(1'b1, 1'b1, BASE + 32'h3FFC, 4'h0, 32'h0, 1'b1);
    drain(ok);
    checks++;
    if (got_q.size() != 5) begin
      errors++; $display("FAIL fault_count: got %0d want 5", got_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (got_q[i] !== want[i]) begin
          errors++; $display("FAIL fault_rsp%0d: got %h want %h", i, got_q[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int nxt, acc_cnt;
    logic [33:0] held;
    logic        held_vld;
    clear_q();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h8000_0100 + 32'(4*i), 4'hF, 32'hA5A5_0000 + 32'(i), 1'b1);
    drain(ok);
    clear_q();
    nxt = 0; acc_cnt = 0; held_vld = 1'b0; held = '0;
    for (int c = 0; c < 6; c++) begin
      step(1'b1, 1'b1, 32'h8000_0100 + 32'(4*nxt), 4'h0, 32'h0, 1'b0);
      if (s_acc) begin acc_cnt++; nxt++; end
      if (held_vld) begin
        checks++;
        if (s_vld !== 1'b1 || s_rsp !== held) begin
          errors++; $display("FAIL stall_stable: vld=%b rsp=%h want 1/%h", s_vld, s_rsp, held);
        end
      end
      held_vld = s_vld;
      held     = s_rsp;
    end
    checks++;
    if (acc_cnt != DEPTH) begin errors++; $display("FAIL stall_accepts: got %0d want %0d", acc_cnt, DEPTH); end
    checks++;
    if (s_rdy !== 1'b0) begin errors++; $display("FAIL stall_rdy: got %b want 0", s_rdy); end
    step(1'b1, 1'b1, 32'h8000_0100 + 32'(4*nxt), 4'h0, 32'h0, 1'b1);
    checks++;
    if (s_pop !== 1'b1 || s_rdy !== 1'b1) begin
      errors++; $display("FAIL release_rdy: pop=%b req_rdy=%b want 1/1", s_pop, s_rdy);
    end
    drain(ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL bp_drain: got %0d want %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL bp_rsp%0d: got %h want %h", i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int bad_acc, bad_pop;
    clear_q();
    bad_acc = 0; bad_pop = 0;
    for (int k = 0; k < 16; k++) begin
      step(1'b1, 1'b1, 32'h8000_0100 + 32'(4*(k % 6)), 4'h0, 32'h0, 1'b1);
      if (s_acc !== 1'b1) bad_acc++;
      if (k > 0 && s_pop !== 1'b1) bad_pop++;
    end
    idle(1'b1);
    if (s_pop !== 1'b1) bad_pop++;
    checks++;
    if (bad_acc != 0) begin errors++; $display("FAIL b2b_accept: stalls=%0d want 0", bad_acc); end
    checks++;
    if (bad_pop != 0) begin errors++; $display("FAIL b2b_rsp_gap: gaps=%0d want 0", bad_pop); end
    drain(ok);
    checks++;
    if (got_q.size() != 16 || !ok) begin
      errors++; $display("FAIL b2b_count: got %0d want 16", got_q.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL b2b_rsp%0d: got %h want %h", i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    bit have_req;
    logic        r_vld, r_rd, rrdy, held_vld;
    logic [31:0] r_addr, r_data;
    logic [3:0]  r_mask;
    logic [33:0] held;
    clear_q();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'h8000_0200 + 32'(4*i), 4'hF, $urandom, 1'b1);
    drain(ok);
    clear_q();
    have_req = 0; held_vld = 1'b0; held = '0;
    r_vld = 0; r_rd = 1; r_addr = '0; r_data = '0; r_mask = '0;
    for (int c = 0; c < 300; c++) begin
      if (!have_req) begin
        r_vld = ($urandom_range(0, 3) != 0);
        if (r_vld) begin
          have_req = 1;
          r_rd   = $urandom_range(0, 1) == 1;
          r_mask = 4'($urandom_range(0, 15));
          r_data = $urandom;
          case ($urandom_range(0, 9))
            0:       r_addr = 32'h7FFF_FFFC;
            1:       r_addr = BASE + 32'h4000 + 32'($urandom_range(0, 255) * 4);
            default: r_addr = 32'h8000_0200 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
          endcase
        end
      end
      rrdy = ($urandom_range(0, 2) != 0);
      step(r_vld, r_rd, r_addr, r_mask, r_data, rrdy);
      if (s_acc) begin have_req = 0; r_vld = 0; end
      if (held_vld) begin
        checks++;
        if (s_vld !== 1'b1 || s_rsp !== held) begin
          errors++; $display("FAIL rand_stable c%0d: vld=%b rsp=%h want 1/%h", c, s_vld, s_rsp, held);
        end
      end
      held_vld = s_vld & ~s_pop;
      held     = s_rsp;
    end
    drain(ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL rand_drain: got %0d want %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL rand_rsp%0d: got %h want %h", i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int stale;
    clear_q();
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 1'b1, 32'h8000_0100 + 32'(4*i), 4'h0, 32'h0, 1'b0);
      checks++;
      if (s_acc !== 1'b1) begin errors++; $display("FAIL rstmid_fill%0d: got %b want 1", i, s_acc); end
    end
    @(negedge clk);
    req_vld = 1'b0;
    rsp_rdy = 1'b0;
    #1;
    checks++;
    if (rsp_vld !== 1'b1) begin errors++; $display("FAIL rstmid_pre_vld: got %b want 1", rsp_vld); end
    rst = 1'b1;
    #1;
    checks++;
    if (rsp_vld !== 1'b0 || rsp_data !== 32'h0) begin
      errors++; $display("FAIL rstmid_async: vld=%b data=%h want 0/0", rsp_vld, rsp_data);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (req_rdy !== 1'b1) begin errors++; $display("FAIL rstmid_rdy: got %b want 1", req_rdy); end
    clear_q();
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      idle(1'b1);
      if (s_vld !== 1'b0) stale++;
    end
    checks++;
    if (stale != 0) begin errors++; $display("FAIL rstmid_stale: got %0d want 0", stale); end
    step(1'b1, 1'b0, 32'h8000_0040, 4'hF, 32'h1357_9BDF, 1'b1);
    step(1'b1, 1'b1, 32'h8000_0040, 4'h0, 32'h0, 1'b1);
    drain(ok);
    checks++;
    if (got_q.size() != 2 || !ok) begin
      errors++; $display("FAIL rstmid_after_count: got %0d want 2", got_q.size());
    end else begin
      checks++;
      if (got_q[1] !== {2'b00, 32'h1357_9BDF}) begin
        errors++; $display("FAIL rstmid_after_data: got %h want %h", got_q[1], {2'b00, 32'h1357_9BDF});
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_mask();
    test_fault();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
